// File: rtl/shift_reg_univ_pkg.sv
// Shared definitions for the universal shift register: operating mode encodings.
package shift_reg_univ_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHL  = 2'b01,
    MODE_SHR  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

endpackage : shift_reg_univ_pkg

// File: rtl/shift_frame_cnt.sv
// Bit counter that frames SHLEN-bit words: counts enabled shifts, wraps at
// SHLEN-1 and flags the wrapping shift so the parent can latch a finished word.
module shift_frame_cnt #(
  parameter int SHLEN = 8,
  parameter int CNTW  = $clog2(SHLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  output logic [CNTW-1:0] cnt,
  output logic            wrap
);

  localparam logic [CNTW-1:0] LAST = CNTW'(SHLEN - 1);

  // The wrapping shift is the one that takes the count from SHLEN-1 back to 0.
  assign wrap = en && !clr && (cnt == LAST);

  // Count enabled shifts; clear has priority and discards any partial word.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, regardless of the order of statements or blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNTW'(1);
    end
  end

endmodule : shift_frame_cnt

// File: rtl/shift_reg_univ.sv
// Universal shift register: left/right serial shift, parallel load, serial
// output, word framing into a holding register with valid/ready and overflow.
module shift_reg_univ
  import shift_reg_univ_pkg::*;
#(
  parameter int SHLEN = 8,
  parameter int CNTW  = $clog2(SHLEN)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CLR,
  input  logic [1:0]       MODE,
  input  logic             SIN,
  input  logic [SHLEN-1:0] PIN,
  output logic             SOUT,
  output logic [SHLEN-1:0] SHREG,
  output logic [CNTW-1:0]  BITCNT,
  output logic [SHLEN-1:0] DOUT,
  output logic             DOUT_VLD,
  input  logic             DOUT_RDY,
  output logic             OVF
);

  mode_e            mode;
  logic             shift_en;
  logic             cnt_clr;
  logic             word_done;
  logic [SHLEN-1:0] shreg_nxt;

  assign mode     = mode_e'(MODE);
  assign shift_en = (mode == MODE_SHL) || (mode == MODE_SHR);
  // A parallel load restarts word framing from the loaded contents.
  assign cnt_clr  = CLR || (mode == MODE_LOAD);

  shift_frame_cnt #(
    .SHLEN (SHLEN),
    .CNTW  (CNTW)
  ) u_cnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (cnt_clr),
    .en    (shift_en),
    .cnt   (BITCNT),
    .wrap  (word_done)
  );

  // Next shift register value for the selected mode.
  // NOTE: give every always_comb output a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    shreg_nxt = SHREG;
    unique case (mode)
      MODE_SHL:  shreg_nxt = {SHREG[SHLEN-2:0], SIN};
      MODE_SHR:  shreg_nxt = {SIN, SHREG[SHLEN-1:1]};
      MODE_LOAD: shreg_nxt = PIN;
      default:   shreg_nxt = SHREG;
    endcase
  end

  // The bit leaving the register on the next shift: LSB when shifting right.
  assign SOUT = (mode == MODE_SHR) ? SHREG[0] : SHREG[SHLEN-1];

  // Shift register, holding register, handshake and sticky overflow.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      SHREG    <= '0;
      DOUT     <= '0;
      DOUT_VLD <= 1'b0;
      OVF      <= 1'b0;
    end else if (CLR) begin
      SHREG    <= '0;
      DOUT     <= '0;
      DOUT_VLD <= 1'b0;
      OVF      <= 1'b0;
    end else begin
      SHREG <= shreg_nxt;
      if (word_done) begin
        // A finished word always replaces DOUT; losing an unaccepted one is flagged.
        DOUT     <= shreg_nxt;
        DOUT_VLD <= 1'b1;
        if (DOUT_VLD && !DOUT_RDY) begin
          OVF <= 1'b1;
        end
      end else if (DOUT_VLD && DOUT_RDY) begin
        DOUT_VLD <= 1'b0;
      end
    end
  end

endmodule : shift_reg_univ

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench for shift_reg_univ (SHLEN=8): directed vectors, a
// behavioural word-level model checked every cycle, and literal spot checks.
module tb_shift_reg_univ;

  localparam int SHLEN = 8;
  localparam int CNTW  = $clog2(SHLEN);

  logic             clk;
  logic             rst_n;
  logic             clr;
  logic [1:0]       mode;
  logic             sin;
  logic [SHLEN-1:0] pin;
  logic             sout;
  logic [SHLEN-1:0] shreg;
  logic [CNTW-1:0]  bitcnt;
  logic [SHLEN-1:0] dout;
  logic             dout_vld;
  logic             dout_rdy;
  logic             ovf;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 0;

  shift_reg_univ #(.SHLEN(SHLEN)) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .CLR      (clr),
    .MODE     (mode),
    .SIN      (sin),
    .PIN      (pin),
    .SOUT     (sout),
    .SHREG    (shreg),
    .BITCNT   (bitcnt),
    .DOUT     (dout),
    .DOUT_VLD (dout_vld),
    .DOUT_RDY (dout_rdy),
    .OVF      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (integer word arithmetic) ----------------
  int unsigned m_reg, m_cnt, m_dout;
  bit          m_vld, m_ovf;

  always @(posedge clk or negedge rst_n) begin
    int unsigned nr;
    bit          done;
    if (!rst_n) begin
      m_reg = 0; m_cnt = 0; m_dout = 0; m_vld = 0; m_ovf = 0;
    end else if (clr) begin
      m_reg = 0; m_cnt = 0; m_dout = 0; m_vld = 0; m_ovf = 0;
    end else begin
      nr   = m_reg;
      done = 0;
      case (mode)
        2'b01: begin nr = (m_reg * 2 + sin) % (1 << SHLEN); m_cnt = (m_cnt + 1) % SHLEN; done = (m_cnt == 0); end
        2'b10: begin nr = m_reg / 2 + sin * (1 << (SHLEN - 1)); m_cnt = (m_cnt + 1) % SHLEN; done = (m_cnt == 0); end
        2'b11: begin nr = pin; m_cnt = 0; end
        default: ;
      endcase
      if (done) begin
        if (m_vld && !dout_rdy) m_ovf = 1;
        m_dout = nr;
        m_vld  = 1;
      end else if (m_vld && dout_rdy) begin
        m_vld = 0;
      end
      m_reg = nr;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("shreg",    32'(shreg),    m_reg);
      check("bitcnt",   32'(bitcnt),   m_cnt);
      check("dout",     32'(dout),     m_dout);
      check("dout_vld", 32'(dout_vld), 32'(m_vld));
      check("ovf",      32'(ovf),      32'(m_ovf));
      check("sout",     32'(sout),     (mode == 2'b10) ? (m_reg & 1) : ((m_reg >> (SHLEN - 1)) & 1));
    end
  end

  // One clock with the given inputs; returns 1 time unit after the falling edge.
  task automatic cycle(input logic [1:0] m, input logic s, input logic r, input logic c);
    mode = m; sin = s; dout_rdy = r; clr = c;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic shift_word(input logic [1:0] m, input logic [7:0] w, input logic r);
    for (int i = 0; i < 8; i++) begin
      cycle(m, (m == 2'b01) ? w[7 - i] : w[i], r, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] stream;
    logic [7:0] exp_sout;
    rst_n = 1'b0; clr = 1'b0; mode = 2'b00; sin = 1'b0; pin = '0; dout_rdy = 1'b0;
    #12;
    check("reset_shreg", 32'(shreg), 0);
    check("reset_vld",   32'(dout_vld), 0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    cmp_en = 1;

    // MSB-first framing: first bit ends in the MSB.
    stream = 8'b1011_0010;
    for (int i = 0; i < 8; i++) cycle(2'b01, stream[7 - i], 1'b1, 1'b0);
    check("msb_dout",   32'(dout), 32'hB2);
    check("msb_vld",    32'(dout_vld), 1);
    check("msb_bitcnt", 32'(bitcnt), 0);
    check("msb_ovf",    32'(ovf), 0);
    cycle(2'b00, 1'b0, 1'b1, 1'b0);
    check("msb_vld_pulse", 32'(dout_vld), 0);

    // LSB-first framing: same stream, first bit ends in the LSB.
    for (int i = 0; i < 8; i++) cycle(2'b10, stream[7 - i], 1'b1, 1'b0);
    check("lsb_dout", 32'(dout), 32'h4D);
    check("lsb_vld",  32'(dout_vld), 1);
    cycle(2'b00, 1'b0, 1'b1, 1'b0);
    check("lsb_vld_pulse", 32'(dout_vld), 0);

    // Load then serialise MSB first.
    pin = 8'hA5;
    cycle(2'b11, 1'b0, 1'b1, 1'b0);
    check("load_no_done", 32'(dout_vld), 0);
    check("load_shreg",   32'(shreg), 32'hA5);
    exp_sout = 8'b1010_0101;
    for (int i = 0; i < 8; i++) begin
      mode = 2'b01; sin = 1'b0;
      #1;
      check("load_sout", 32'(sout), 32'(exp_sout[7 - i]));
      cycle(2'b01, 1'b0, 1'b1, 1'b0);
    end
    check("load_dout", 32'(dout), 32'h00);
    check("load_vld",  32'(dout_vld), 1);
    cycle(2'b00, 1'b0, 1'b1, 1'b0);

    // Overflow with the consumer stalled, then synchronous clear.
    shift_word(2'b01, 8'h11, 1'b0);
    check("ovf_first", 32'(ovf), 0);
    shift_word(2'b01, 8'h22, 1'b0);
    check("ovf_dout", 32'(dout), 32'h22);
    check("ovf_vld",  32'(dout_vld), 1);
    check("ovf_flag", 32'(ovf), 1);
    cycle(2'b01, 1'b1, 1'b1, 1'b1);
    check("clr_ovf",  32'(ovf), 0);
    check("clr_vld",  32'(dout_vld), 0);
    check("clr_dout", 32'(dout), 0);

    // Back-to-back words with the consumer always ready.
    shift_word(2'b01, 8'hC3, 1'b1);
    check("b2b_first", 32'(dout), 32'hC3);
    shift_word(2'b01, 8'h5A, 1'b1);
    check("b2b_second", 32'(dout), 32'h5A);
    check("b2b_ovf",    32'(ovf), 0);
    cycle(2'b00, 1'b0, 1'b1, 1'b0);

    // Leave an untransferred word and an overflow pending, then async reset mid-word.
    shift_word(2'b01, 8'h0F, 1'b0);
    shift_word(2'b01, 8'hF0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(2'b01, 1'b1, 1'b0, 1'b0);
    check("pre_rst_bitcnt", 32'(bitcnt), 5);
    #1 rst_n = 1'b0;
    #1;
    check("arst_shreg",  32'(shreg), 0);
    check("arst_bitcnt", 32'(bitcnt), 0);
    check("arst_dout",   32'(dout), 0);
    check("arst_vld",    32'(dout_vld), 0);
    check("arst_ovf",    32'(ovf), 0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    shift_word(2'b01, 8'h96, 1'b1);
    check("post_rst_dout", 32'(dout), 32'h96);
    check("post_rst_vld",  32'(dout_vld), 1);
    cycle(2'b00, 1'b0, 1'b1, 1'b0);

    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_shift_reg_univ
